// File: rtl/mux_n_rr.sv
// N-channel registered stream mux with manual and round-robin selection.
// One-entry output register; in_ready is a one-hot grant gated by load.
module mux_n_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [SEL_W:0]   NW   = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] nxt;
  logic [SEL_W:0]   pk;
  logic [WIDTH-1:0] cdata;
  logic             found;
  logic             load;
  logic             xfer;

  assign load = !out_valid || out_ready;

  // Candidate search: fixed sel, or first valid from ptr upward (mod N)
  always_comb begin
    found = 1'b0;
    cand  = '0;
    pk    = '0;
    if (mode) begin
      for (int k = 0; k < N; k++) begin
        pk = {1'b0, ptr} + (SEL_W+1)'(k);
        if (pk >= NW) pk = pk - NW;
        if (!found && in_valid[pk[SEL_W-1:0]]) begin
          found = 1'b1;
          cand  = pk[SEL_W-1:0];
        end
      end
    end else if ({1'b0, sel} < NW) begin
      found = 1'b1;
      cand  = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && found) in_ready[cand] = load;
  end

  always_comb begin
    cdata = '0;
    for (int i = 0; i < N; i++)
      if (cand == SEL_W'(i)) cdata = in_data[i*WIDTH +: WIDTH];
  end

  assign xfer = |(in_valid & in_ready);
  assign nxt  = (cand == LAST) ? '0 : cand + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= cdata;
      out_ch    <= cand;
      if (mode) ptr <= nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mux_n_rr.md
# mux_n_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with a valid/ready handshake on every input and on the output. It generalises the combinational 4:1 mux into a streaming channel selector for the datapath. A manual mode forwards the channel chosen by `sel`. A round-robin mode scans all channels fairly. A one-entry output register holds data under backpressure.

## Interface
- `WIDTH`, 8: data width per channel, ≥1.
- `N`, 4: channel count, ≥2; derived `SEL_W = max(1, $clog2(N))`.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous active-low reset.
- `in_data` in N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` in N: per-channel valid.
- `in_ready` out N: per-channel ready; combinational; at most one bit high.
- `mode` in 1: 0 = manual (use `sel`), 1 = round-robin.
- `sel` in SEL_W: manual channel index.
- `out_data` out WIDTH: registered selected data.
- `out_ch` out SEL_W: index of the channel that produced `out_data`.
- `out_valid` out 1: output register full.
- `out_ready` in 1: downstream accepts.

## Operation
- Reset values (`rst_n`=0 at a clock edge): `out_valid`=0, `out_data`=0, `out_ch`=0, round-robin pointer `ptr`=0.
  - `in_ready` is all-zero whenever `rst_n`=0, combinationally.
- Load-enable: `load = !out_valid || out_ready`. The register accepts a new beat in the same cycle it drains.
- Candidate channel `c`:
  - Manual: `c = sel`.
    - If `sel ≥ N`, there is no candidate and `in_ready` is all-zero.
  - Round-robin: `c` is the first i with `in_valid[i]`=1, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1` (mod N).
    - If no channel is valid, there is no candidate.
- `in_ready[c] = load` for a valid candidate; all other bits are 0.
  - In manual mode, `in_ready[sel]` may be high while `in_valid[sel]`=0. Only the AND of the two transfers.
- Transfer on channel c (`in_valid[c] && in_ready[c]`): next edge sets `out_data = in_data[c]`, `out_ch = c`, `out_valid = 1`.
- Pointer update, round-robin mode only: on a transfer, `ptr ← (c+1) mod N`.
  - The pointer wraps from N-1 to 0.
  - In manual mode `ptr` is held. Switching mode never resets `ptr`.
- No transfer and `out_ready`=1: `out_valid ← 0`. `out_data` and `out_ch` hold their last values.
- `out_valid && !out_ready`: `out_data` and `out_ch` are stable and `in_ready` is all-zero.
- `mode` or `sel` changes take effect combinationally in the same cycle. They never alter a beat already in the output register.
- Reset asserted mid-stream: the held beat is discarded, `out_valid`=0 on the next edge, and no input is consumed on that edge.

## Timing
- Latency: transfer at edge k gives `out_valid`=1 with data from cycle k visible after edge k.
- Throughput: 1 beat/cycle while `out_ready`=1 and a candidate is valid. There are no bubbles between beats.
- Round-robin fairness: with all N channels continuously valid and `out_ready`=1, each channel is granted exactly once per N consecutive cycles.
- Combinational paths:
  - `in_valid`/`mode`/`sel`/`out_ready` → `in_ready`.
  - There is no combinational path to `out_data`, `out_valid` or `out_ch`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with all `in_valid`=1. Required: `out_valid`=0, `out_data`=0, `in_ready`=0000; after release, the first grant in round-robin mode is channel 0.
- Manual sweep (N=4, WIDTH=8): for sel = 0..3, drive `in_data` = {8'hDD,8'hCC,8'hBB,8'hAA} with only channel sel valid and `out_ready`=1. Required, one cycle later: `out_data` = AA/BB/CC/DD and `out_ch` = sel. Also `sel`=... n/a for N=4; rerun with N=5 and `sel`=7: `in_ready` all-zero and `out_valid` stays 0.
- Backpressure: load 8'h5A, then hold `out_ready`=0 for 3 cycles with another channel valid. Required: `out_data`=5A held, `in_ready`=0 throughout; with `out_ready`=1, the next beat loads on the same edge the held beat drains.
- Round-robin fairness: all 4 channels valid, `out_ready`=1 for 9 cycles. Required: `out_ch` sequence 0,1,2,3,0,1,2,3,0.
- Round-robin skip/wrap: `ptr`=3 with only channels 1 and 3 valid. Required: grants 3,1,3,1 (wrap through 0); drop channel 3 and only channel 1 is granted, back-to-back.
- Mid-stream reset: during round-robin streaming with `out_valid`=1, pulse `rst_n`=0 for 1 cycle. Required: `out_valid`=0 and `ptr`=0 after the edge, and the next grant is channel 0.
